// File: rtl/tuner_pkg.sv
// Shared types and helpers for the tuner front end that drives the FFT core.
package tuner_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        LOAD,
        START,
        WAIT,
        READ,
        REPORT
    } seq_state_t;

    // Absolute value of a sign-extended word; callers size-cast the result back down.
    // The most negative input maps to its unsigned magnitude, with no saturation.
    function automatic logic [63:0] abs_w(input logic signed [63:0] v);
        logic [63:0] u;
        u = v;
        return u[63] ? (~u + 64'd1) : u;
    endfunction

endpackage

// File: rtl/fft_mag_peak.sv
// Running peak tracker over FFT bins: |re|+|im| magnitude, keeps the first bin
// holding the strictly largest magnitude since the last clear.
module fft_mag_peak
    import tuner_pkg::*;
#(
    parameter int width = 16,
    parameter int BIN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [BIN_W-1:0]   bin,
    input  logic [2*width-1:0] data,
    output logic [BIN_W-1:0]   peak_bin,
    output logic [width:0]     peak_mag
);

    logic [width:0] mag;

    // Each abs fits in width bits, so the width+1 bit sum cannot overflow.
    assign mag = (width+1)'(abs_w(64'(signed'(data[2*width-1:width]))))
               + (width+1)'(abs_w(64'(signed'(data[width-1:0]))));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_bin <= '0;
            peak_mag <= '0;
        end else if (clr) begin
            peak_bin <= '0;
            peak_mag <= '0;
        end else if (en && (mag > peak_mag)) begin
            peak_bin <= bin;
            peak_mag <= mag;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the FFT core: loads 2^M samples, starts the transform,
// scans bins 1..N/2-1 for the largest |re|+|im| and reports it.
module fft_frame_sequencer
    import tuner_pkg::*;
#(
    parameter int width    = 16,
    parameter int M        = 9,
    parameter int READ_LAT = 1,
    parameter int TIMEOUT  = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [width-1:0]   sample,
    output logic               fft_reset,
    output logic               fft_load,
    output logic               fft_start,
    output logic [M-1:0]       fft_adr,
    output logic [2*width-1:0] fft_rd,
    input  logic [2*width-1:0] fft_wd,
    input  logic               fft_done,
    output logic               peak_valid,
    output logic [M-2:0]       peak_bin,
    output logic [width:0]     peak_mag,
    output logic               dropped,
    output logic               fft_error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(READ_LAT + 2);

    seq_state_t      state;
    logic [M-1:0]    load_cnt;
    logic [M-2:0]    read_cnt;
    logic            issue_done;
    logic [DW-1:0]   drain_cnt;
    logic [TW-1:0]   wait_cnt;

    // Stage 0 is aligned with fft_adr; stage READ_LAT is aligned with valid fft_wd.
    logic [READ_LAT:0] rd_vld;
    logic [M-2:0]      rd_bin [READ_LAT:0];

    logic              trk_clr;
    logic [M-2:0]      trk_bin;
    logic [width:0]    trk_mag;

    assign trk_clr = (state == WAIT) && fft_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            load_cnt   <= '0;
            read_cnt   <= '0;
            issue_done <= 1'b0;
            drain_cnt  <= '0;
            wait_cnt   <= '0;
            rd_vld     <= '0;
            fft_reset  <= 1'b0;
            fft_load   <= 1'b0;
            fft_start  <= 1'b0;
            fft_adr    <= '0;
            fft_rd     <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            dropped    <= 1'b0;
            fft_error  <= 1'b0;
        end else begin
            fft_reset  <= 1'b0;
            fft_load   <= 1'b0;
            fft_start  <= 1'b0;
            peak_valid <= 1'b0;
            fft_error  <= 1'b0;
            dropped    <= sample_valid && (state != LOAD);

            for (int i = READ_LAT; i > 0; i--) rd_vld[i] <= rd_vld[i-1];
            rd_vld[0] <= 1'b0;

            case (state)
                CLEAR: begin
                    fft_reset <= 1'b1;
                    fft_adr   <= '0;
                    load_cnt  <= '0;
                    state     <= LOAD;
                end
                LOAD: begin
                    if (sample_valid) begin
                        fft_load <= 1'b1;
                        fft_adr  <= load_cnt;
                        fft_rd   <= {sample, {width{1'b0}}};
                        load_cnt <= load_cnt + M'(1);
                        if (load_cnt == '1) state <= START;
                    end
                end
                START: begin
                    fft_start <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (fft_done) begin
                        read_cnt   <= (M-1)'(1);
                        issue_done <= 1'b0;
                        drain_cnt  <= '0;
                        state      <= READ;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        fft_error <= 1'b1;
                        state     <= CLEAR;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                READ: begin
                    // Bin 0 and the mirrored upper half are never addressed.
                    if (!issue_done) begin
                        fft_adr   <= {1'b0, read_cnt};
                        rd_vld[0] <= 1'b1;
                        read_cnt  <= read_cnt + (M-1)'(1);
                        if (read_cnt == '1) issue_done <= 1'b1;
                    end else if (drain_cnt == DW'(READ_LAT)) begin
                        state <= REPORT;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                REPORT: begin
                    peak_valid <= 1'b1;
                    peak_bin   <= trk_bin;
                    peak_mag   <= trk_mag;
                    state      <= CLEAR;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // NOTE: the bin-tag pipeline is data only, qualified by rd_vld, so it is
    // deliberately left without a reset.
    always_ff @(posedge clk) begin
        rd_bin[0] <= read_cnt;
        for (int i = READ_LAT; i > 0; i--) rd_bin[i] <= rd_bin[i-1];
    end

    fft_mag_peak #(
        .width (width),
        .BIN_W (M-1)
    ) u_peak (
        .clk      (clk),
        .reset    (reset),
        .clr      (trk_clr),
        .en       (rd_vld[READ_LAT]),
        .bin      (rd_bin[READ_LAT]),
        .data     (fft_wd),
        .peak_bin (trk_bin),
        .peak_mag (trk_mag)
    );

endmodule
